pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program-counter unit; successor to the fixed-increment PC.
- Holds the fetch address and selects the next PC from sequential increment, branch, jump or exception vector, with stall support.
- Generates a fixed-length flush pulse after every redirect.
- Sits at the head of the fetch stage and drives instruction-memory address.

Parameters:
- WIDTH, 32, PC/address width in bits.
- FIRST_ADDRESS, 0, PC value loaded on reset.
- PC_INC, 4, sequential increment in bytes; power of two.
- EXC_VECTOR, 32'h0000_0080, PC loaded on exception.
- FLUSH_CYCLES, 1, cycles flush stays high after a redirect; range 1..15.
- RAS_DEPTH, 4, return-address-stack entries; used only with PC_RAS_EN.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- stall  in  1  hold PC; blocks the sequential increment only.
- branch_taken  in  1  take branch this cycle.
- branch_offset  in  WIDTH  signed byte offset, relative to pc_plus.
- jump  in  1  absolute jump this cycle.
- jump_target  in  WIDTH  absolute byte address.
- exception  in  1  redirect to EXC_VECTOR.
- pc  out  WIDTH  current fetch address.
- pc_plus  out  WIDTH  pc + PC_INC; combinational.
- flush  out  1  high while in FLUSH state.
- misaligned  out  1  registered; last redirect target had nonzero low log2(PC_INC) bits.

Behaviour:
- Reset (reset==0 at the edge):
  - pc=FIRST_ADDRESS, flush=0, misaligned=0, state=RUN, flush counter=0.
  - Reset overrides every other input, including mid-FLUSH.
- Next-PC priority, evaluated each edge:
  1. exception -> EXC_VECTOR.
  2. jump -> jump_target.
  3. branch_taken -> pc_plus + branch_offset.
  4. stall -> pc (hold).
  5. otherwise -> pc_plus.
- Redirects (exception/jump/branch) are accepted even while stall=1.
- Redirect targets are loaded with low log2(PC_INC) bits cleared. misaligned is set from the original bits on any redirect and cleared on any non-redirect update. Exception is always aligned.
- Arithmetic is modulo 2^WIDTH: all-ones region wraps to 0; negative offsets wrap correctly.
- Latency: new pc is visible one cycle after the request edge; pc_plus follows combinationally.
- State machine:
  - RUN: a redirect -> FLUSH, counter=FLUSH_CYCLES-1, flush=1 from the next cycle.
  - FLUSH: flush=1. Counter decrements each cycle; at 0 with no new redirect -> RUN.
  - A new redirect in FLUSH reloads the counter and applies its target. PC updates continue in FLUSH per the priority list.
- Simultaneous jump and branch_taken: jump wins; the branch is dropped silently.

Optional Feature:
- Macro PC_RAS_EN.
- Defined:
  - Adds ports call (in, 1) and ret (in, 1).
  - call with jump pushes pc_plus onto a RAS_DEPTH-entry circular stack.
  - ret (priority between jump and branch) loads the top of stack and pops.
  - Overflow overwrites the oldest entry.
  - Pop on empty loads pc_plus and sets misaligned=0.
  - Reset empties the stack.
- Undefined: no call/ret ports, no stack storage; behaviour exactly as above.

Decomposition:
- Shared package pc_pkg:
  - State enum {RUN, FLUSH}.
  - Next-PC select enum {SEL_EXC, SEL_JMP, SEL_RET, SEL_BR, SEL_HOLD, SEL_INC}.
  - Default EXC_VECTOR constant.
- One sub-module, pc_ras (return-address stack), instantiated only under PC_RAS_EN.

Test Plan (FIRST_ADDRESS=16, PC_INC=4, FLUSH_CYCLES=2, WIDTH=32 unless stated):
- Reset low 1 cycle, release, free-run 4 cycles -> pc 16, 20, 24, 28, 32; flush=0 throughout.
- stall high 3 cycles at pc=24 -> pc holds 24, then resumes 28.
- At pc=32, branch_taken with offset -16 -> pc=20 next cycle; flush=1 for exactly 2 cycles.
- jump and branch_taken together, target 0x100 -> pc=0x100. Then jump to 0x102 -> pc=0x100, misaligned=1.
- exception together with jump and stall -> pc=0x80. Reset asserted during FLUSH -> pc=16, flush=0 next cycle.
- WIDTH=8, FIRST_ADDRESS=8'hFC -> pc FC then 00 (wrap). With PC_RAS_EN: call+jump at 16 to 0x40, then ret -> pc=20.

Source files
------------

// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg
// Shared types and constants for the program-counter unit.
//   state_t   : flush sequencer states (RUN, FLUSH)
//   nextSel_t : source of the next PC value, listed in priority order
//   DEFAULT_EXC_VECTOR : reset value of the exception vector parameter
// Optional feature macro used by the files importing this package: PC_RAS_EN
// ---------------------------------------------------------------------------
package pc_pkg;

   typedef enum logic {
      RUN,
      FLUSH
   } state_t;

   typedef enum logic [2:0] {
      SEL_EXC,
      SEL_JMP,
      SEL_RET,
      SEL_BR,
      SEL_HOLD,
      SEL_INC
   } nextSel_t;

   localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0080;

endpackage

// File: rtl/pc_unit_if.sv
// ---------------------------------------------------------------------------
// pc_unit_if
// Groups the control/redirect inputs and the fetch-address outputs of the
// program-counter unit.
//   master : the driver of stall/branch/jump/exception (fetch control)
//   slave  : the pc_unit itself
// Signals: stall, branch_taken, branch_offset, jump, jump_target, exception
//          (to the unit); pc, pc_plus, flush, misaligned (from the unit).
// With PC_RAS_EN defined, call and ret are added (to the unit).
// ---------------------------------------------------------------------------
interface pc_unit_if #(
   parameter int WIDTH = 32
);

   logic             stall;
   logic             branch_taken;
   logic [WIDTH-1:0] branch_offset;
   logic             jump;
   logic [WIDTH-1:0] jump_target;
   logic             exception;
`ifdef PC_RAS_EN
   logic             call;
   logic             ret;
`endif
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] pc_plus;
   logic             flush;
   logic             misaligned;

   modport master (
      output stall, branch_taken, branch_offset, jump, jump_target, exception,
`ifdef PC_RAS_EN
      output call, ret,
`endif
      input  pc, pc_plus, flush, misaligned
   );

   modport slave (
      input  stall, branch_taken, branch_offset, jump, jump_target, exception,
`ifdef PC_RAS_EN
      input  call, ret,
`endif
      output pc, pc_plus, flush, misaligned
   );

endinterface

// File: rtl/pc_ras.sv
// ---------------------------------------------------------------------------
// pc_ras
// Circular return-address stack. Only instantiated when PC_RAS_EN is defined.
//   clk, reset  : clock, synchronous active-low reset (empties the stack)
//   push_i      : write pushData_i as the new top of stack
//   pushData_i  : return address to save
//   pop_i       : discard the top entry (ignored when empty)
//   top_o       : current top-of-stack value
//   empty_o     : no valid entries
// Pushing onto a full stack silently overwrites the oldest entry.
// ---------------------------------------------------------------------------
module pc_ras #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] pushData_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] top_o,
   output logic             empty_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] entries [DEPTH];
   logic [PTR_W-1:0] ptr_q, ptr_d, nextPtr, prevPtr;
   logic [CNT_W-1:0] count_q, count_d;

   // The pointer always addresses the top entry; wrapping it around the
   // array is what makes an overflowing push replace the oldest entry.
   always_comb begin
      nextPtr = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
      prevPtr = (ptr_q == '0) ? PTR_W'(DEPTH - 1) : ptr_q - 1'b1;
      ptr_d   = ptr_q;
      count_d = count_q;
      if (push_i) begin
         ptr_d   = nextPtr;
         count_d = (count_q == CNT_W'(DEPTH)) ? count_q : count_q + 1'b1;
      end else if (pop_i && (count_q != '0)) begin
         ptr_d   = prevPtr;
         count_d = count_q - 1'b1;
      end
   end

   // Pointer and occupancy registers; reset only needs to empty the stack.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ptr_q   <= '0;
         count_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         count_q <= count_d;
      end
   end

   // Entry storage carries no reset since occupancy guards every read.
   always_ff @(posedge clk) begin
      if (reset && push_i) begin
         entries[nextPtr] <= pushData_i;
      end
   end

   assign top_o   = entries[ptr_q];
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
// Program counter at the head of the fetch stage. Selects the next fetch
// address from exception vector, jump, (return), branch, hold or sequential
// increment, and raises flush for FLUSH_CYCLES cycles after every redirect.
//   clk   : rising-edge clock
//   reset : synchronous, active-low reset
//   bus   : pc_unit_if.slave -- redirect/stall inputs, pc, pc_plus, flush,
//           misaligned outputs
// Optional feature macro: PC_RAS_EN adds call/ret and a return-address stack.
// ---------------------------------------------------------------------------
module pc_unit
   import pc_pkg::*;
#(
   parameter int               WIDTH         = 32,
   parameter logic [WIDTH-1:0] FIRST_ADDRESS = '0,
   parameter int               PC_INC        = 4,
   parameter logic [WIDTH-1:0] EXC_VECTOR    = WIDTH'(DEFAULT_EXC_VECTOR),
   parameter int               FLUSH_CYCLES  = 1,
   parameter int               RAS_DEPTH     = 4
) (
   input  logic     clk,
   input  logic     reset,
   pc_unit_if.slave bus
);

   localparam logic [WIDTH-1:0] INC        = WIDTH'(PC_INC);
   localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(PC_INC - 1);
   localparam logic [3:0]       CNT_RELOAD = 4'(FLUSH_CYCLES - 1);

   logic [WIDTH-1:0] pc_q, pc_d;
   logic             misaligned_q, misaligned_d;
   state_t           state_q, state_d;
   logic [3:0]       flushCnt_q, flushCnt_d;
   nextSel_t         nextSel;
   logic [WIDTH-1:0] pcPlus;
   logic [WIDTH-1:0] rawTarget;
   logic             redirect;

`ifdef PC_RAS_EN
   logic [WIDTH-1:0] rasTop;
   logic             rasEmpty;
   logic             rasPush;
   logic             rasPop;
`endif

   assign pcPlus = pc_q + INC;

   // Next-PC source in priority order; redirects deliberately outrank stall.
   always_comb begin
      nextSel = SEL_INC;
      if (bus.exception) begin
         nextSel = SEL_EXC;
      end else if (bus.jump) begin
         nextSel = SEL_JMP;
`ifdef PC_RAS_EN
      end else if (bus.ret) begin
         nextSel = SEL_RET;
`endif
      end else if (bus.branch_taken) begin
         nextSel = SEL_BR;
      end else if (bus.stall) begin
         nextSel = SEL_HOLD;
      end
   end

   // Redirect targets are forced onto an instruction boundary; the dropped
   // low bits are remembered in misaligned so software can see the fault.
   always_comb begin
      pc_d         = pcPlus;
      misaligned_d = 1'b0;
      rawTarget    = '0;
      redirect     = 1'b0;
      case (nextSel)
         SEL_EXC: begin
            redirect = 1'b1;
            pc_d     = EXC_VECTOR;
         end
         SEL_JMP: begin
            redirect     = 1'b1;
            rawTarget    = bus.jump_target;
            pc_d         = rawTarget & ~ALIGN_MASK;
            misaligned_d = |(rawTarget & ALIGN_MASK);
         end
`ifdef PC_RAS_EN
         SEL_RET: begin
            redirect = 1'b1;
            if (!rasEmpty) begin
               rawTarget    = rasTop;
               pc_d         = rawTarget & ~ALIGN_MASK;
               misaligned_d = |(rawTarget & ALIGN_MASK);
            end
         end
`endif
         SEL_BR: begin
            redirect     = 1'b1;
            rawTarget    = pcPlus + bus.branch_offset;
            pc_d         = rawTarget & ~ALIGN_MASK;
            misaligned_d = |(rawTarget & ALIGN_MASK);
         end
         SEL_HOLD: begin
            pc_d         = pc_q;
            misaligned_d = misaligned_q;
         end
         default: ;
      endcase
   end

   // Flush sequencer: every redirect (re)starts the countdown, so back-to-back
   // redirects keep flush asserted until the last one has fully drained.
   always_comb begin
      state_d    = state_q;
      flushCnt_d = flushCnt_q;
      case (state_q)
         RUN: begin
            if (redirect) begin
               state_d    = FLUSH;
               flushCnt_d = CNT_RELOAD;
            end
         end
         FLUSH: begin
            if (redirect) begin
               flushCnt_d = CNT_RELOAD;
            end else if (flushCnt_q == 4'd0) begin
               state_d = RUN;
            end else begin
               flushCnt_d = flushCnt_q - 4'd1;
            end
         end
         default: state_d = RUN;
      endcase
   end

   // State registers; reset wins over any redirect or flush in progress.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q         <= FIRST_ADDRESS;
         misaligned_q <= 1'b0;
         state_q      <= RUN;
         flushCnt_q   <= 4'd0;
      end else begin
         pc_q         <= pc_d;
         misaligned_q <= misaligned_d;
         state_q      <= state_d;
         flushCnt_q   <= flushCnt_d;
      end
   end

`ifdef PC_RAS_EN
   // A call only saves its return address when its jump is actually taken.
   assign rasPush = (nextSel == SEL_JMP) && bus.call;
   assign rasPop  = (nextSel == SEL_RET);

   pc_ras #(
      .WIDTH (WIDTH),
      .DEPTH (RAS_DEPTH)
   ) uRas (
      .clk        (clk),
      .reset      (reset),
      .push_i     (rasPush),
      .pushData_i (pcPlus),
      .pop_i      (rasPop),
      .top_o      (rasTop),
      .empty_o    (rasEmpty)
   );
`endif

   assign bus.pc         = pc_q;
   assign bus.pc_plus    = pcPlus;
   assign bus.flush      = (state_q == FLUSH);
   assign bus.misaligned = misaligned_q;

endmodule

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit
// Directed bench for pc_unit. Instance A: WIDTH=32, FIRST_ADDRESS=16,
// PC_INC=4, FLUSH_CYCLES=2. Instance B: WIDTH=8, FIRST_ADDRESS=8'hFC to
// exercise address wrap. Return-stack steps run only with PC_RAS_EN.
// ---------------------------------------------------------------------------
module tb_pc_unit;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;

   pc_unit_if #(.WIDTH(32)) busA ();
   pc_unit_if #(.WIDTH(8))  busB ();

   pc_unit #(
      .WIDTH         (32),
      .FIRST_ADDRESS (32'd16),
      .PC_INC        (4),
      .FLUSH_CYCLES  (2)
   ) dutA (
      .clk   (clk),
      .reset (reset),
      .bus   (busA.slave)
   );

   pc_unit #(
      .WIDTH         (8),
      .FIRST_ADDRESS (8'hFC),
      .PC_INC        (4)
   ) dutB (
      .clk   (clk),
      .reset (reset),
      .bus   (busB.slave)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drives every redirect/stall input of instance A in one call.
   task automatic applyStimulus(input logic st, input logic br, input logic [31:0] off,
                                input logic jmp, input logic [31:0] tgt, input logic exc);
      busA.stall         = st;
      busA.branch_taken  = br;
      busA.branch_offset = off;
      busA.jump          = jmp;
      busA.jump_target   = tgt;
      busA.exception     = exc;
   endtask

   // One comparison: counts the vector and reports any miscompare.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Advance past the next rising edge so outputs are sampled settled.
   task automatic stepClock();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      busB.stall         = 1'b0;
      busB.branch_taken  = 1'b0;
      busB.branch_offset = 8'd0;
      busB.jump          = 1'b0;
      busB.jump_target   = 8'd0;
      busB.exception     = 1'b0;
`ifdef PC_RAS_EN
      busA.call = 1'b0;
      busA.ret  = 1'b0;
      busB.call = 1'b0;
      busB.ret  = 1'b0;
`endif

      // Reset state of both instances.
      stepClock();
      checkOutput("rst_pc",         busA.pc,         32'd16);
      checkOutput("rst_flush",      busA.flush,      32'd0);
      checkOutput("rst_misaligned", busA.misaligned, 32'd0);
      checkOutput("rst_pc_plus",    busA.pc_plus,    32'd20);
      checkOutput("w8_rst_pc",      busB.pc,         32'hFC);
      checkOutput("w8_pc_plus",     busB.pc_plus,    32'h00);
      reset = 1'b1;

      // Free run.
      stepClock();
      checkOutput("run_pc20",  busA.pc,    32'd20);
      checkOutput("run_flush", busA.flush, 32'd0);
      checkOutput("w8_wrap",   busB.pc,    32'h00);
      stepClock();
      checkOutput("run_pc24", busA.pc, 32'd24);

      // Stall holds for three cycles then resumes.
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         stepClock();
         checkOutput("stall_hold", busA.pc, 32'd24);
      end
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      stepClock();
      checkOutput("stall_resume", busA.pc, 32'd28);
      stepClock();
      checkOutput("run_pc32", busA.pc,    32'd32);
      checkOutput("run_flush32", busA.flush, 32'd0);

      // Backward branch: 36 - 16 = 20, flush for exactly two cycles.
      applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF0, 1'b0, 32'd0, 1'b0);
      stepClock();
      checkOutput("br_pc",     busA.pc,    32'd20);
      checkOutput("br_flush1", busA.flush, 32'd1);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      stepClock();
      checkOutput("br_pc24",   busA.pc,    32'd24);
      checkOutput("br_flush2", busA.flush, 32'd1);
      stepClock();
      checkOutput("br_pc28",   busA.pc,    32'd28);
      checkOutput("br_flush3", busA.flush, 32'd0);

      // Jump beats branch; then a misaligned jump target.
      applyStimulus(1'b0, 1'b1, 32'd8, 1'b1, 32'h100, 1'b0);
      stepClock();
      checkOutput("jmp_pc",    busA.pc,         32'h100);
      checkOutput("jmp_mis",   busA.misaligned, 32'd0);
      checkOutput("jmp_flush", busA.flush,      32'd1);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'h102, 1'b0);
      stepClock();
      checkOutput("mis_pc",    busA.pc,         32'h100);
      checkOutput("mis_flag",  busA.misaligned, 32'd1);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      stepClock();
      checkOutput("mis_clear", busA.misaligned, 32'd0);
      checkOutput("mis_pc104", busA.pc,         32'h104);
      checkOutput("reload_flush", busA.flush,   32'd1);
      stepClock();
      checkOutput("reload_end", busA.flush, 32'd0);

      // Exception outranks jump and stall; reset then cuts the flush short.
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 32'h200, 1'b1);
      stepClock();
      checkOutput("exc_pc",    busA.pc,    32'h80);
      checkOutput("exc_flush", busA.flush, 32'd1);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      reset = 1'b0;
      stepClock();
      checkOutput("flushrst_pc",    busA.pc,    32'd16);
      checkOutput("flushrst_flush", busA.flush, 32'd0);
      reset = 1'b1;
      stepClock();
      checkOutput("postrst_pc",    busA.pc,    32'd20);
      checkOutput("postrst_flush", busA.flush, 32'd0);

      // Branch with an odd offset: 24 + 6 = 30 aligns down to 28.
      applyStimulus(1'b0, 1'b1, 32'd6, 1'b0, 32'd0, 1'b0);
      stepClock();
      checkOutput("brmis_pc",  busA.pc,         32'd28);
      checkOutput("brmis_mis", busA.misaligned, 32'd1);
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      stepClock();
      checkOutput("brmis_next", busA.pc,         32'd32);
      checkOutput("brmis_clr",  busA.misaligned, 32'd0);

`ifdef PC_RAS_EN
      // Call at 16 saves 20; ret returns there; ret on empty falls through.
      reset = 1'b0;
      stepClock();
      reset = 1'b1;
      checkOutput("ras_start", busA.pc, 32'd16);
      busA.call = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 32'h40, 1'b0);
      stepClock();
      checkOutput("call_pc", busA.pc, 32'h40);
      busA.call = 1'b0;
      busA.ret  = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
      stepClock();
      checkOutput("ret_pc", busA.pc, 32'd20);
      stepClock();
      checkOutput("ret_empty_pc",  busA.pc,         32'd24);
      checkOutput("ret_empty_mis", busA.misaligned, 32'd0);
      busA.ret = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
